pa_writeback: RTL and testbench
===============================

Name: pa_writeback

Overview:
- Writeback stage of the add pipeline; sits directly downstream of the execute stage and consumes its registered ALU result.
- Aligns the decode-stage destination index with the one-cycle execute latency and commits results into a 32 x 32-bit register file.
- Serves two combinational read ports back to decode, with an optional same-cycle write-through bypass.
- Reports each retirement and keeps a saturating retired-instruction count.

Parameters:
- DATA_W, 32, data width of ALU result and register entries.
- ADDR_W, 5, register index width; register file depth is 2**ADDR_W.

Ports:
- clk  input  1  pipeline clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- aluresult  input  DATA_W  registered result from execute, valid the cycle after its operands were sampled.
- write_dest  input  ADDR_W  destination index from decode, presented in the same cycle as the operands entering execute.
- dest_valid  input  1  write_dest qualifies a real instruction.
- rd_addr_1  input  ADDR_W  decode read index A.
- rd_addr_2  input  ADDR_W  decode read index B.
- rd_data_1  output  DATA_W  combinational read data A.
- rd_data_2  output  DATA_W  combinational read data B.
- wb_valid  output  1  registered; high for one cycle per retirement.
- wb_dest  output  ADDR_W  registered index just committed.
- wb_data  output  DATA_W  registered value just committed.
- retired_count  output  32  retirements since reset, saturating.

Behaviour:
- Reset (async, immediate):
  - dest_d = 0, dest_valid_d = 0.
  - All register file entries = 0.
  - wb_valid = 0, wb_dest = 0, wb_data = 0, retired_count = 0.
- Alignment stage, every posedge:
  - dest_d <= write_dest.
  - dest_valid_d <= dest_valid.
  - Result: dest_d/dest_valid_d pair with the aluresult produced at the same edge.
- Commit, posedge with dest_valid_d = 1:
  - rf[dest_d] <= aluresult, unless dest_d = 0.
  - wb_valid <= 1, wb_dest <= dest_d, wb_data <= aluresult, including dest_d = 0.
  - retired_count <= retired_count + 1, holding at 32'hFFFF_FFFF.
- Posedge with dest_valid_d = 0: wb_valid <= 0; wb_dest, wb_data, rf and retired_count hold.
- Register 0 always reads 0 and is never written.
- Latency: write_dest sampled at edge N; commit and wb_* update at edge N+1.
- Reads: rd_data_x = rf[rd_addr_x]; index 0 returns 0. Both ports are independent and may use the same index.
- Back-to-back instructions to the same destination commit in order, one per cycle; the last one wins.
- Reset asserted mid-stream discards the in-flight dest_d. No commit occurs on the deassertion edge unless dest_valid was sampled high after release.

Optional Feature:
- Macro: PA_WB_BYPASS_EN.
- Defined:
  - If dest_valid_d = 1, dest_d != 0 and rd_addr_x = dest_d, then rd_data_x = aluresult (the value committing this cycle).
  - Otherwise rd_data_x is the stored register value.
- Undefined:
  - rd_data_x reflects stored contents only.
  - A value being committed becomes visible the cycle after the commit edge.

Test Plan:
- Reset, then read rd_addr_1 = 7 and rd_addr_2 = 31 -> both 0; wb_valid = 0; retired_count = 0.
- Drive write_dest = 3, dest_valid = 1 at edge N, with aluresult = 32'd25 after edge N:
  - Edge N+1: wb_valid = 1, wb_dest = 3, wb_data = 25, retired_count = 1.
  - Afterwards rd_addr_1 = 3 returns 25.
- Write_dest = 0 with aluresult = 32'hDEAD_BEEF:
  - wb_valid = 1, wb_dest = 0, retired_count increments.
  - rd_addr_2 = 0 still returns 0.
- Back-to-back: dest 5 = 10, then dest 5 = 20 on consecutive cycles -> rf[5] = 20; two wb_valid pulses with wb_data 10 then 20.
- Bypass: read rd_addr_1 = 9 in the commit cycle of dest 9 = 77:
  - With PA_WB_BYPASS_EN: returns 77.
  - Without: returns the old value 0, then 77 the next cycle.
- Reset pulse between edge N and N+1 while dest 4 is in flight -> no commit to r4, rf[4] = 0, retired_count = 0.
- Force retired_count to 32'hFFFF_FFFF and retire one more -> value stays 32'hFFFF_FFFF.

Source files
------------

// File: rtl/pa_writeback_if.sv
//------------------------------------------------------------------------------
// pa_writeback_if
// Bundles the writeback stage's datapath signals so execute/decode-side logic
// and the writeback stage connect through a single port.
//   master : drives aluresult, write_dest, dest_valid, rd_addr_1/2;
//            observes rd_data_1/2, wb_valid, wb_dest, wb_data, retired_count.
//   slave  : the writeback stage (mirror image of master).
//------------------------------------------------------------------------------
interface pa_writeback_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [DATA_W-1:0] aluresult;
  logic [ADDR_W-1:0] write_dest;
  logic              dest_valid;
  logic [ADDR_W-1:0] rd_addr_1;
  logic [ADDR_W-1:0] rd_addr_2;
  logic [DATA_W-1:0] rd_data_1;
  logic [DATA_W-1:0] rd_data_2;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic [31:0]       retired_count;

  modport master (
    output aluresult, write_dest, dest_valid, rd_addr_1, rd_addr_2,
    input  rd_data_1, rd_data_2, wb_valid, wb_dest, wb_data, retired_count
  );

  modport slave (
    input  aluresult, write_dest, dest_valid, rd_addr_1, rd_addr_2,
    output rd_data_1, rd_data_2, wb_valid, wb_dest, wb_data, retired_count
  );
endinterface

// File: rtl/pa_writeback.sv
//------------------------------------------------------------------------------
// pa_writeback
// Writeback stage of the add pipeline. Delays the decode-stage destination by
// one cycle so it lines up with the registered ALU result, commits into a
// 32-entry register file (entry 0 hard-wired to zero), serves two
// combinational read ports, and reports each retirement with a saturating
// retired-instruction counter.
//
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : pa_writeback_if.slave
//             in  aluresult, write_dest, dest_valid, rd_addr_1, rd_addr_2
//             out rd_data_1, rd_data_2 (combinational)
//             out wb_valid, wb_dest, wb_data, retired_count (registered)
//
// Optional build macro:
//   PA_WB_BYPASS_EN : read ports return the value being committed this cycle
//                     when they address the committing destination. Without
//                     it, reads reflect stored contents only.
//------------------------------------------------------------------------------
module pa_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic           clk,
  input logic           reset,
  pa_writeback_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [ADDR_W-1:0] dest_d_r;
  logic              dest_valid_d_r;
  logic [DATA_W-1:0] rf_r [DEPTH];
  logic              wb_valid_r;
  logic [ADDR_W-1:0] wb_dest_r;
  logic [DATA_W-1:0] wb_data_r;
  logic [31:0]       retired_count_r;
  logic              rf_we_s;
  logic [DATA_W-1:0] rd_data_1_s;
  logic [DATA_W-1:0] rd_data_2_s;

  // Read mux for one port: index 0 is zero, optional bypass of the value
  // committing at the next edge, otherwise the stored entry.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              commit_v,
    input logic [ADDR_W-1:0] commit_dest,
    input logic [DATA_W-1:0] commit_data
  );
    logic [DATA_W-1:0] value;
    if (addr == {ADDR_W{1'b0}}) begin
      value = {DATA_W{1'b0}};
    end else begin
`ifdef PA_WB_BYPASS_EN
      if (commit_v && (commit_dest == addr)) begin
        value = commit_data;
      end else begin
        value = stored;
      end
`else
      value = stored;
`endif
    end
    return value;
  endfunction

  // Register index 0 is never written, even when an instruction targets it.
  assign rf_we_s = dest_valid_d_r && (dest_d_r != {ADDR_W{1'b0}});

  // Align the decode-stage destination with the one-cycle execute latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dest_d_r       <= {ADDR_W{1'b0}};
      dest_valid_d_r <= 1'b0;
    end else begin
      dest_d_r       <= bus.write_dest;
      dest_valid_d_r <= bus.dest_valid;
    end
  end

  // Register file storage; commits the aligned result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        rf_r[i] <= {DATA_W{1'b0}};
      end
    end else if (rf_we_s) begin
      rf_r[dest_d_r] <= bus.aluresult;
    end else begin
      rf_r[dest_d_r] <= rf_r[dest_d_r];
    end
  end

  // Retirement report and saturating retirement counter; a write to index 0
  // still retires and is reported.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid_r      <= 1'b0;
      wb_dest_r       <= {ADDR_W{1'b0}};
      wb_data_r       <= {DATA_W{1'b0}};
      retired_count_r <= 32'd0;
    end else if (dest_valid_d_r) begin
      wb_valid_r <= 1'b1;
      wb_dest_r  <= dest_d_r;
      wb_data_r  <= bus.aluresult;
      if (retired_count_r != 32'hFFFF_FFFF) begin
        retired_count_r <= retired_count_r + 32'd1;
      end else begin
        retired_count_r <= retired_count_r;
      end
    end else begin
      wb_valid_r <= 1'b0;
    end
  end

  // Combinational read ports back to decode.
  always_comb begin
    rd_data_1_s = read_port(bus.rd_addr_1, rf_r[bus.rd_addr_1], rf_we_s, dest_d_r, bus.aluresult);
    rd_data_2_s = read_port(bus.rd_addr_2, rf_r[bus.rd_addr_2], rf_we_s, dest_d_r, bus.aluresult);
  end

  assign bus.rd_data_1     = rd_data_1_s;
  assign bus.rd_data_2     = rd_data_2_s;
  assign bus.wb_valid      = wb_valid_r;
  assign bus.wb_dest       = wb_dest_r;
  assign bus.wb_data       = wb_data_r;
  assign bus.retired_count = retired_count_r;

endmodule

// File: tb/tb_pa_writeback.sv
//------------------------------------------------------------------------------
// tb_pa_writeback
// Randomized, scoreboard-checked bench for pa_writeback. The stimulus process
// drives one instruction slot per cycle, keeps an architectural model of the
// register file and retirement count, and queues every expected retirement;
// a separate monitor pops the queue whenever wb_valid is seen.
//------------------------------------------------------------------------------
module tb_pa_writeback;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
    logic [31:0]   count;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pa_writeback_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  pa_writeback #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  exp_t          sb_q[$];
  int            tests = 0;
  int            fails = 0;
  logic [DW-1:0] rf_m [32];
  logic [31:0]   count_m;
  logic          pend_v;
  logic [AW-1:0] pend_dest;
  logic [DW-1:0] pend_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural view of a read: r0 is zero; with bypass the instruction
  // committing at the next edge is visible immediately.
  function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
    if (a == 5'd0) return 32'd0;
`ifdef PA_WB_BYPASS_EN
    if (pend_v && pend_dest == a) return pend_data;
`endif
    return rf_m[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    count_m = 32'd0;
    pend_v  = 1'b0;
    pend_dest = 5'd0;
    pend_data = 32'd0;
  endtask

  // One cycle: present the result of the previously issued instruction,
  // issue a new one, check reads, then account for the upcoming commit.
  task automatic step(input logic nv, input logic [AW-1:0] nd, input logic [DW-1:0] ndata,
                      input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
    exp_t e;
    @(negedge clk);
    bus.aluresult  = pend_v ? pend_data : $urandom;
    bus.write_dest = nd;
    bus.dest_valid = nv;
    bus.rd_addr_1  = ra1;
    bus.rd_addr_2  = ra2;
    #1;
    chk("rd_data_1", bus.rd_data_1, model_read(ra1));
    chk("rd_data_2", bus.rd_data_2, model_read(ra2));
    chk("retired_count", bus.retired_count, count_m);
    if (pend_v) begin
      if (pend_dest != 5'd0) rf_m[pend_dest] = pend_data;
      if (count_m != 32'hFFFF_FFFF) count_m = count_m + 32'd1;
      e.dest  = pend_dest;
      e.data  = pend_data;
      e.count = count_m;
      sb_q.push_back(e);
    end
    pend_v    = nv;
    pend_dest = nd;
    pend_data = ndata;
  endtask

  // Monitor: every retirement pulse must match the oldest expected one.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (bus.wb_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_unexpected: got wb_valid=1 dest=%0d data=%h expected no retirement",
                   bus.wb_dest, bus.wb_data);
        end else begin
          e = sb_q.pop_front();
          chk("wb_dest", 32'(bus.wb_dest), 32'(e.dest));
          chk("wb_data", bus.wb_data, e.data);
          chk("wb_count", bus.retired_count, e.count);
        end
      end
    end
  end

  initial begin
    logic [AW-1:0] nd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          nv;
    model_clear();
    reset          = 1'b1;
    bus.aluresult  = 32'd0;
    bus.write_dest = 5'd0;
    bus.dest_valid = 1'b0;
    bus.rd_addr_1  = 5'd7;
    bus.rd_addr_2  = 5'd31;
    #2;
    chk("reset_rd1", bus.rd_data_1, 32'd0);
    chk("reset_rd2", bus.rd_data_2, 32'd0);
    chk("reset_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("reset_count", bus.retired_count, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic commit, then visibility on the read port.
    step(1'b1, 5'd3, 32'd25, 5'd7, 5'd31);
    step(1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    step(1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
    // Write to r0 retires but never sticks.
    step(1'b1, 5'd0, 32'hDEAD_BEEF, 5'd3, 5'd0);
    step(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'd0, 5'd1, 5'd0);
    // Back-to-back to the same destination: last wins.
    step(1'b1, 5'd5, 32'd10, 5'd5, 5'd0);
    step(1'b1, 5'd5, 32'd20, 5'd5, 5'd5);
    step(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    step(1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
    // Read in the commit cycle of dest 9.
    step(1'b1, 5'd9, 32'd77, 5'd9, 5'd0);
    step(1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
    step(1'b0, 5'd0, 32'd0, 5'd9, 5'd9);

    // Reset while dest 4 is in flight: nothing may commit.
    step(1'b1, 5'd4, 32'h0000_0044, 5'd4, 5'd9);
    @(negedge clk);
    reset          = 1'b1;
    bus.dest_valid = 1'b0;
    #1;
    chk("midreset_wb_valid", 32'(bus.wb_valid), 32'd0);
    chk("midreset_count", bus.retired_count, 32'd0);
    model_clear();
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    step(1'b0, 5'd0, 32'd0, 5'd4, 5'd9);
    step(1'b0, 5'd0, 32'd0, 5'd4, 5'd5);

    // Saturation: preload the counter just below the ceiling.
    step(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    force dut.retired_count_r = 32'hFFFF_FFFE;
    #1;
    release dut.retired_count_r;
    count_m = 32'hFFFF_FFFE;
    step(1'b1, 5'd6, 32'd1, 5'd0, 5'd0);
    step(1'b1, 5'd7, 32'd2, 5'd6, 5'd0);
    step(1'b1, 5'd8, 32'd3, 5'd7, 5'd6);
    step(1'b0, 5'd0, 32'd0, 5'd8, 5'd7);
    step(1'b0, 5'd0, 32'd0, 5'd8, 5'd6);

    // Randomized traffic, biased toward a few registers and toward reads of
    // the instruction about to commit.
    for (int i = 0; i < 400; i++) begin
      nv  = ($urandom_range(0, 9) < 7);
      nd  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 2) == 0) ? pend_dest : 5'($urandom_range(0, 31));
      ra2 = ($urandom_range(0, 2) == 0) ? pend_dest : 5'($urandom_range(0, 31));
      step(nv, nd, $urandom, ra1, ra2);
    end

    step(1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
    step(1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
    step(1'b0, 5'd0, 32'd0, 5'd5, 5'd6);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
